// File: rtl/arya_pipe_pkg.sv
// Shared types and constants for the Arya five-stage pipeline control blocks.
// Holds the sequencer FSM states, the hard-wired zero register and the default memory timeout.
package arya_pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_state_e;

   localparam int REG_ZERO            = 0;
   localparam int DEFAULT_MEM_TIMEOUT = 64;

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW comparator: flags when either decode source matches an in-flight writer.
// Register zero is hard-wired and never produces a hazard.
module raw_hazard_detect
   import arya_pipe_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic                  rs1_used,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   input  logic                  rs2_used,
   input  logic [ADDR_WIDTH-1:0] ex_wr_addr,
   input  logic                  ex_wr_en,
   input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
   input  logic                  mem_wr_en,
   output logic                  raw
);

   function automatic logic src_hazard(input logic [ADDR_WIDTH-1:0] rs, input logic used);
      return used && (rs != ADDR_WIDTH'(REG_ZERO)) &&
             ((ex_wr_en && (ex_wr_addr == rs)) || (mem_wr_en && (mem_wr_addr == rs)));
   endfunction

   assign raw = src_hazard(rs1_addr, rs1_used) || src_hazard(rs2_addr, rs2_used);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: RAW stalls, taken-branch flushes and memory-wait freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import arya_pipe_pkg::*;
#(
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT        = DEFAULT_MEM_TIMEOUT
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_WIDTH          = 32
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                          id_rs1_used,
   input  logic                          id_rs2_used,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ex_wr_addr,
   input  logic                          ex_wr_en,
   input  logic [REGFILE_ADDR_WIDTH-1:0] mem_wr_addr,
   input  logic                          mem_wr_en,
   input  logic                          branch_taken,
   input  logic                          mem_req,
   input  logic                          mem_ready,
   output logic                          pc_en,
   output logic                          if_id_en,
   output logic                          id_ex_en,
   output logic                          ex_mem_en,
   output logic                          if_id_flush,
   output logic                          id_ex_flush,
   output logic                          mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]          stall_cnt,
   output logic [CNT_WIDTH-1:0]          flush_cnt,
   output logic [CNT_WIDTH-1:0]          memwait_cnt
`endif
);

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   pipe_state_e       state;
   pipe_state_e       next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;
   logic              raw;
   logic              mem_timeout_fire;
   logic              mem_hold;

   raw_hazard_detect #(
      .ADDR_WIDTH (REGFILE_ADDR_WIDTH)
   ) u_raw (
      .rs1_addr    (id_rs1_addr),
      .rs1_used    (id_rs1_used),
      .rs2_addr    (id_rs2_addr),
      .rs2_used    (id_rs2_used),
      .ex_wr_addr  (ex_wr_addr),
      .ex_wr_en    (ex_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_en   (mem_wr_en),
      .raw         (raw)
   );

   // The timeout cycle is treated as a completed access so the pipe is never frozen longer than MEM_TIMEOUT.
   assign mem_timeout_fire = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign mem_hold         = mem_req && !mem_ready && !mem_timeout_fire;
   assign mem_timeout      = timeout_q && !reset;

   always_comb begin
      next_state  = state;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (mem_hold) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (raw) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
      case (state)
         RUN:      if (mem_hold) next_state = MEM_WAIT;
         MEM_WAIT: if (mem_ready || mem_timeout_fire) next_state = RUN;
         default:  next_state = RUN;
      endcase
   end

   // The wait counter is held at zero in RUN, so it starts from zero on every MEM_WAIT entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= next_state;
         timeout_q <= timeout_q | mem_timeout_fire;
         if (state == RUN) wait_cnt <= '0;
         else              wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_q;
   logic [CNT_WIDTH-1:0] flush_q;
   logic [CNT_WIDTH-1:0] memwait_q;
   logic                 stall_ev;
   logic                 flush_ev;

   assign stall_ev    = !mem_hold && !branch_taken && raw;
   assign flush_ev    = !mem_hold && branch_taken;
   assign stall_cnt   = reset ? '0 : stall_q;
   assign flush_cnt   = reset ? '0 : flush_q;
   assign memwait_cnt = reset ? '0 : memwait_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q   <= '0;
         flush_q   <= '0;
         memwait_q <= '0;
      end else begin
         if (stall_ev && (stall_q != '1))   stall_q   <= stall_q + CNT_WIDTH'(1);
         if (flush_ev && (flush_q != '1))   flush_q   <= flush_q + CNT_WIDTH'(1);
         if (mem_hold && (memwait_q != '1)) memwait_q <= memwait_q + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the Arya core's five-stage pipeline. It drives the enable and synchronous-clear inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers (`pipe_decode_execute` and its siblings). It detects RAW hazards against in-flight writers and freezes the pipe while the data memory is busy. It flushes wrong-path instructions on taken branches.

## Interface
- `REGFILE_ADDR_WIDTH`, 5, register address width
- `MEM_TIMEOUT`, 64, maximum memory-wait cycles before forced release (≥2)
- `CNT_WIDTH`, 32, performance counter width (only with `HAZARD_PERF_CNT_EN`)

- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `id_rs1_addr`, `id_rs2_addr` in REGFILE_ADDR_WIDTH, source registers of the instruction in decode
- `id_rs1_used`, `id_rs2_used` in 1, source actually read
- `ex_wr_addr`, `ex_wr_en` in REGFILE_ADDR_WIDTH/1, destination held in the ID/EX register
- `mem_wr_addr`, `mem_wr_en` in REGFILE_ADDR_WIDTH/1, destination held in the EX/MEM register
- `branch_taken` in 1, EX stage resolved beq/bneq as taken
- `mem_req` in 1, MEM stage holds a load or store
- `mem_ready` in 1, data memory completes the request this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1, register enables
- `if_id_flush`, `id_ex_flush` out 1, drive the pipeline registers' `reset` (OR'd with global reset externally)
- `mem_timeout` out 1, sticky error flag
- `stall_cnt`, `flush_cnt`, `memwait_cnt` out CNT_WIDTH, performance counters (macro only)

## Operation
- FSM states: RUN, MEM_WAIT. Reset to RUN.
- RAW hazard (`raw`): for each source i, `id_rsi_used` && rsi≠0, and either (`ex_wr_en` && `ex_wr_addr`==rsi) or (`mem_wr_en` && `mem_wr_addr`==rsi). Register 0 never hazards. There is no forwarding.
- `mem_hold` = `mem_req` && !`mem_ready` && !`mem_timeout_fire`.
- Priority: reset > mem_hold > branch_taken > raw.
- mem_hold: all enables are 0 and all flushes are 0, so the whole pipe freezes.
- branch_taken (no hold): all enables are 1, `if_id_flush`=`id_ex_flush`=1. PC loads the target, and both wrong-path instructions become bubbles. A simultaneous raw is ignored, because the dependent instruction is being flushed.
- raw only: `pc_en`=`if_id_en`=0, `id_ex_en`=1, `id_ex_flush`=1 (bubble inserted), `ex_mem_en`=1. Repeats every cycle until raw clears, which takes a maximum of 2 cycles.
- Otherwise: all enables are 1 and all flushes are 0.
- FSM transitions:
  - RUN→MEM_WAIT when mem_hold.
  - MEM_WAIT→RUN when `mem_ready`, or when the wait counter reaches MEM_TIMEOUT−1.
- Wait counter: clears on entering MEM_WAIT and increments each MEM_WAIT cycle, up to ⌈log2 MEM_TIMEOUT⌉ bits.
- `mem_timeout_fire`: asserted combinationally in the cycle the counter equals MEM_TIMEOUT−1. That cycle behaves as if `mem_ready`=1 (pipe advances), and `mem_timeout` sets on the next edge and stays set until reset.

## Timing
- All enable and flush outputs are combinational from inputs and state, with zero latency, and take effect at the next `clk` edge.
- During `reset` high, outputs are: enables 1, flushes 1, `mem_timeout`=0, counters 0. State is RUN and the wait counter is 0 after the edge.
- A load with a dependent successor stalls 2 cycles; a dependent instruction two behind a writer stalls 1 cycle.
- A taken branch costs 2 bubbles.
- A memory wait of N cycles freezes for exactly N cycles, never more than MEM_TIMEOUT.
- `mem_ready` on the same cycle as `mem_req` produces no freeze and no MEM_WAIT entry.
- Reset mid-MEM_WAIT returns to RUN immediately.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: three saturating counters are present, and each increments once per cycle:
  - `stall_cnt`: raw-stall cycles.
  - `flush_cnt`: branch-flush cycles.
  - `memwait_cnt`: mem_hold cycles.
- Undefined: the counter ports and logic are absent.

## Structure
- Shared package `arya_pipe_pkg` holds:
  - the FSM state enum (RUN, MEM_WAIT);
  - the register-zero constant;
  - the default MEM_TIMEOUT.
- One sub-module is natural: `raw_hazard_detect`, the combinational source/destination comparator, instantiated once with both sources.

## Test plan
- Writer r3 in ID/EX and decode reads r3 (rs1_used=1) -> exactly 2 cycles of `pc_en`=0 with `id_ex_flush`=1, then RUN with all enables 1.
- Decode reads r0 while ID/EX writes r0 -> no stall.
- `branch_taken`=1 together with a raw hazard -> `if_id_flush`=`id_ex_flush`=1 and all enables 1 for one cycle; `flush_cnt`+1.
- `mem_req`=1 with `mem_ready` low for 5 cycles -> all enables 0 for 5 cycles; the cycle with `mem_ready` high advances; `memwait_cnt`=5.
- `mem_ready` never asserted, MEM_TIMEOUT=8 -> release on the 8th wait cycle; `mem_timeout`=1 thereafter until reset.
- `reset` asserted in cycle 3 of MEM_WAIT -> next cycle state RUN, counters 0, `mem_timeout`=0.
